// File: rtl/addsub_rr_arbiter.sv
// ============================================================================
// addsub_rr_arbiter
// ----------------------------------------------------------------------------
// Shares one external 16-bit adder/subtractor among NUM_REQ requesters.
// A round-robin arbiter picks one valid requester in IDLE. Its operands are
// latched and driven to the shared unit for one EXEC cycle. The result is
// captured and then held in RESP until the consumer takes it.
// The sequence is IDLE -> EXEC -> RESP -> IDLE, so at most one op is in flight.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake; ready is one-hot or zero,
//                        and only in IDLE
//   req_a/req_b          packed operands, requester i at [16*i+15:16*i]
//   req_mod              per-requester op select, 0 = add, 1 = subtract
//   alu_a/alu_b/alu_mod  to the shared adder; these hold the last issued op
//   alu_y/alu_ovf        from the shared adder (combinational, same cycle)
//   rsp_valid/rsp_ready  result handshake
//   rsp_y/rsp_ovf/rsp_id result, raw carry-out, index of the issuing requester
//
// Configuration
//   ADDSUB_ARB_PERF_EN   when defined, adds two outputs:
//                        busy_cnt (saturating count of non-IDLE cycles)
//                        grant_cnt (wrapping count of accepts)
// ============================================================================
module addsub_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_mod,
    output logic [15:0]             alu_a,
    output logic [15:0]             alu_b,
    output logic                    alu_mod,
    input  logic [15:0]             alu_y,
    input  logic                    alu_ovf,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_y,
    output logic                    rsp_ovf,
    output logic [ID_W-1:0]         rsp_id
`ifdef ADDSUB_ARB_PERF_EN
    ,
    output logic [15:0]             busy_cnt,
    output logic [15:0]             grant_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                         r_state;
    logic [ID_W-1:0]                r_rr_ptr;
    logic [15:0]                    r_alu_a;
    logic [15:0]                    r_alu_b;
    logic                           r_alu_mod;
    logic [ID_W-1:0]                r_id;
    logic                           r_rsp_valid;
    logic [15:0]                    r_rsp_y;
    logic                           r_rsp_ovf;
    logic [ID_W-1:0]                r_rsp_id;

    // Packed views of the operand buses; element i is requester i's field.
    logic [NUM_REQ-1:0][15:0]       w_a_arr;
    logic [NUM_REQ-1:0][15:0]       w_b_arr;

    logic                           w_found;
    logic [ID_W-1:0]                w_grant_idx;
    logic [ID_W-1:0]                w_next_ptr;
    logic [NUM_REQ-1:0]             w_req_ready;
    logic                           w_accept;
    int                             w_dist;
    int                             w_best;

    assign w_a_arr = req_a;
    assign w_b_arr = req_b;

    // Round-robin pick. A requester's rotational distance from rr_ptr is its
    // priority, and the smallest distance wins. This gives the same result as
    // a search that starts at rr_ptr and wraps, without variable indexing.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                w_dist = (i + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ;
                if (w_dist < w_best) begin
                    w_best      = w_dist;
                    w_grant_idx = ID_W'(i);
                    w_found     = 1'b1;
                end
            end
        end

        w_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_ready[i] = (r_state == S_IDLE) && w_found && (w_grant_idx == ID_W'(i));
        end
    end

    // req_ready is only raised for a valid requester, so "found in IDLE" is
    // exactly the valid & ready handshake of the granted requester.
    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_mod   <= 1'b0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // The operand registers also drive the shared unit.
                        // They keep the last issued op until the next accept.
                        r_alu_a   <= w_a_arr[w_grant_idx];
                        r_alu_b   <= w_b_arr[w_grant_idx];
                        r_alu_mod <= req_mod[w_grant_idx];
                        r_id      <= w_grant_idx;
                        r_rr_ptr  <= w_next_ptr;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_y     <= alu_y;
                    r_rsp_ovf   <= alu_ovf;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ADDSUB_ARB_PERF_EN
    logic [15:0] r_busy_cnt;
    logic [15:0] r_grant_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cnt  <= '0;
            r_grant_cnt <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_busy_cnt != 16'hFFFF)) begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end
            if (w_accept) begin
                r_grant_cnt <= r_grant_cnt + 1'b1;
            end
        end
    end

    assign busy_cnt  = r_busy_cnt;
    assign grant_cnt = r_grant_cnt;
`else
`endif

    assign req_ready = w_req_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_mod   = r_alu_mod;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Testbench for addsub_rr_arbiter. Models the shared adder, predicts grants
// and results with a reference model plus a scoreboard queue, and runs
// directed scenarios for add, subtract, round-robin, backpressure, carry
// wrap and reset during an operation.
module tb_addsub_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][15:0]   tb_a = '0;
    logic [N-1:0][15:0]   tb_b = '0;
    logic [N-1:0]         req_mod = '0;
    logic [15:0]          alu_a, alu_b, alu_y;
    logic                 alu_mod, alu_ovf;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [15:0]          rsp_y;
    logic                 rsp_ovf;
    logic [IW-1:0]        rsp_id;
`ifdef ADDSUB_ARB_PERF_EN
    logic [15:0]          busy_cnt, grant_cnt;
`endif

    always #5 clk = ~clk;

    addsub_rr_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (tb_a),
        .req_b     (tb_b),
        .req_mod   (req_mod),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mod   (alu_mod),
        .alu_y     (alu_y),
        .alu_ovf   (alu_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id)
`ifdef ADDSUB_ARB_PERF_EN
        ,
        .busy_cnt  (busy_cnt),
        .grant_cnt (grant_cnt)
`endif
    );

    // Shared carry-out adder/subtractor.
    logic [16:0] sum17;
    assign sum17   = alu_mod ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1)
                             : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_y   = sum17[15:0];
    assign alu_ovf = sum17[16];

    typedef struct {
        logic [15:0]   a;
        logic [15:0]   b;
        logic          mod;
        logic [15:0]   y;
        logic          ovf;
        logic [IW-1:0] id;
    } exp_t;

    typedef enum {M_IDLE, M_EXEC, M_RESP} mstate_t;

    exp_t    sb[$];
    int      log_id[$];
    int      log_cyc[$];
    mstate_t m_state = M_IDLE;
    int      m_ptr = 0;
    int      cyc = 0;
    int      n_checks = 0;
    int      n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model, evaluated mid-cycle. Inputs only change just after a
    // rising edge, so they are stable here. The model state advances to what
    // the DUT should hold after the next rising edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            sb.delete();
            log_id.delete();
            log_cyc.delete();
        end else begin
            logic [N-1:0] e_rdy;
            int           g;
            exp_t         e;
            e_rdy = '0;
            g     = -1;
            if (m_state == M_IDLE) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[IW'((m_ptr + k) % N)]) g = (m_ptr + k) % N;
                end
            end
            if (g >= 0) e_rdy[IW'(g)] = 1'b1;
            check("req_ready", req_ready, e_rdy);
            check("rsp_valid", rsp_valid, m_state == M_RESP);
            case (m_state)
                M_IDLE: begin
                    if (g >= 0) begin
                        e.a   = tb_a[IW'(g)];
                        e.b   = tb_b[IW'(g)];
                        e.mod = req_mod[IW'(g)];
                        e.id  = IW'(g);
                        if (e.mod) begin
                            e.y   = e.a - e.b;
                            e.ovf = (e.a >= e.b);
                        end else begin
                            e.y   = e.a + e.b;
                            e.ovf = (({1'b0, e.a} + {1'b0, e.b}) > 17'h0FFFF);
                        end
                        sb.push_back(e);
                        m_ptr   = (g + 1) % N;
                        m_state = M_EXEC;
                    end
                end
                M_EXEC: begin
                    if (sb.size() > 0) begin
                        e = sb[$];
                        check("alu_a", alu_a, e.a);
                        check("alu_b", alu_b, e.b);
                        check("alu_mod", alu_mod, e.mod);
                    end
                    m_state = M_RESP;
                end
                default: begin
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 0, 1);
                    end else begin
                        e = sb[0];
                        check("rsp_y", rsp_y, e.y);
                        check("rsp_ovf", rsp_ovf, e.ovf);
                        check("rsp_id", rsp_id, e.id);
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            log_id.push_back(int'(e.id));
                            log_cyc.push_back(cyc);
                        end
                    end
                    if (rsp_ready) m_state = M_IDLE;
                end
            endcase
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic m);
        @(posedge clk);
        #1;
        tb_a[IW'(i)]      = a;
        tb_b[IW'(i)]      = b;
        req_mod[IW'(i)]   = m;
        req_valid[IW'(i)] = 1'b1;
    endtask

    // Waits (bounded) for requester i's handshake, then drops its valid.
    task automatic wait_accept(input int i);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(req_valid[IW'(i)] && req_ready[IW'(i)]) && t < 30);
        check("accept_seen", req_valid[IW'(i)] && req_ready[IW'(i)], 1);
        @(posedge clk);
        #1 req_valid[IW'(i)] = 1'b0;
    endtask

    task automatic wait_rsp(input logic [15:0] y, input logic ovf, input logic [IW-1:0] id);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_valid && t < 30);
        check("rsp_seen", rsp_valid, 1);
        check("dir_rsp_y", rsp_y, y);
        check("dir_rsp_ovf", rsp_ovf, ovf);
        check("dir_rsp_id", rsp_id, id);
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(m_state == M_IDLE && sb.size() == 0) && t < 50);
        check("drain_done", (m_state == M_IDLE && sb.size() == 0), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_y"}, rsp_y, 0);
        check({tag, "_rsp_ovf"}, rsp_ovf, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_mod"}, alu_mod, 0);
    endtask

    initial begin
        #1 check_outputs_zero("reset");
        do_reset();

        // Single add, with the latency measured from the accept cycle.
        set_req(0, 16'h1234, 16'h0001, 1'b0);
        wait_accept(0);
        @(negedge clk);
        check("lat_exec_no_rsp", rsp_valid, 0);
        @(negedge clk);
        check("lat_rsp_valid", rsp_valid, 1);
        check("add_y", rsp_y, 16'h1235);
        check("add_ovf", rsp_ovf, 0);
        check("add_id", rsp_id, 0);
        drain();

        // Subtract in both directions.
        set_req(2, 16'h0005, 16'h0007, 1'b1);
        wait_accept(2);
        wait_rsp(16'hFFFE, 1'b0, 2'd2);
        set_req(2, 16'h0007, 16'h0005, 1'b1);
        wait_accept(2);
        wait_rsp(16'h0002, 1'b1, 2'd2);
        drain();

        // Round-robin with all four requesters valid continuously.
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            tb_a[IW'(i)]    = 16'h0100 * 16'(i + 1);
            tb_b[IW'(i)]    = 16'(i * 3 + 1);
            req_mod[IW'(i)] = i[0];
        end
        req_valid = '1;
        repeat (16) @(posedge clk);
        #1 req_valid = '0;
        drain();
        check("rr_count", log_id.size() >= 5, 1);
        if (log_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("rr_id_seq", log_id[k], k % N);
            for (int k = 1; k < 5; k++) check("rr_spacing", log_cyc[k] - log_cyc[k-1], 3);
        end

        // Backpressure while a second requester waits.
        do_reset();
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        set_req(1, 16'h4000, 16'h0123, 1'b0);
        wait_accept(1);
        set_req(3, 16'h0010, 16'h0020, 1'b1);
        wait_rsp(16'h4123, 1'b0, 2'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_ready_low", req_ready, 0);
            check("bp_valid_held", rsp_valid, 1);
            check("bp_y_held", rsp_y, 16'h4123);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake", rsp_valid, 1);
        @(negedge clk);
        check("bp_idle_grant", req_ready, 4'b1000);
        check("bp_idle_no_rsp", rsp_valid, 0);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        drain();

        // Carry wrap.
        set_req(3, 16'hFFFF, 16'h0001, 1'b0);
        wait_accept(3);
        wait_rsp(16'h0000, 1'b1, 2'd3);
        drain();

        // Reset during EXEC after moving the pointer away from 0.
        set_req(1, 16'h0011, 16'h0022, 1'b0);
        wait_accept(1);
        drain();
        set_req(2, 16'hABCD, 16'h0123, 1'b1);
        wait_accept(2);
        rst_n = 1'b0;
        #1 check_outputs_zero("midop_reset");
        tb_a[0] = 16'h0003; tb_b[0] = 16'h0004; req_mod[0] = 1'b0;
        tb_a[3] = 16'h0009; tb_b[3] = 16'h0001; req_mod[3] = 1'b1;
        req_valid = 4'b1001;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_grant", req_ready, 4'b0001);
        check("post_reset_no_rsp", rsp_valid, 0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp(16'h0007, 1'b0, 2'd0);
        wait_accept(3);
        wait_rsp(16'h0008, 1'b1, 2'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
